// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
//
// Purpose: bundles the two valid/ready handshakes of the product accumulator
// into one interface so the upstream multiplier side and the downstream
// consumer side travel together.
//
// Signals:
//   in_valid   upstream offers a product on in_prod
//   in_ready   accumulator accepts the offered product this cycle
//   in_prod    8-bit unsigned product
//   out_valid  out_sum/out_ovf hold a completed batch
//   out_ready  consumer takes the result this cycle
//   out_sum    ACC_W-bit batch sum (wrapped or saturated)
//   out_ovf    batch sum exceeded 2^ACC_W-1
//
// Modports:
//   master  environment side (drives products and out_ready)
//   slave   accumulator side (drives in_ready and the result)
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
   parameter int ACC_W = 12
);

   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;

   modport master (
      output in_valid,
      output in_prod,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_prod,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_ovf
   );

endinterface

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Purpose: sums a fixed batch of COUNT 8-bit products from the 4x4 array
// multiplier into an ACC_W-bit accumulator and presents the batch sum plus
// an overflow flag on an output valid/ready handshake.
//
// Parameters:
//   COUNT  products per batch (1..15)
//   ACC_W  accumulator / result width (8..16)
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_clear  synchronous batch abort (discards partial sum and pending result)
//   io_bus   product_accumulator_if.slave carrying both handshakes
//
// Build option:
//   ACC_SATURATE_EN  when defined, the accumulator clamps to 2^ACC_W-1 on
//                    the first carry and stays clamped for the rest of the
//                    batch; otherwise it wraps modulo 2^ACC_W. out_ovf is
//                    sticky for the batch in both builds.
// ---------------------------------------------------------------------------
module product_accumulator #(
   parameter int COUNT = 4,
   parameter int ACC_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   product_accumulator_if.slave  io_bus
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(COUNT - 1);

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic             r_ovf;
   logic             r_outValid;
   logic [ACC_W-1:0] r_outSum;
   logic             r_outOvf;

   logic             w_inReady;
   logic             w_accept;
   logic [ACC_W:0]   w_sum;
   logic             w_ovfNext;
   logic [ACC_W-1:0] w_accNext;

   // in_ready comes straight from registered state so clear can veto an
   // accept in the same cycle it is raised.
   assign w_inReady = (r_state == ST_ACC) && !i_clear;
   assign w_accept  = io_bus.in_valid && w_inReady;

   // One extra bit catches the carry out of the accumulator.
   assign w_sum     = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, io_bus.in_prod};
   assign w_ovfNext = r_ovf | w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
   // Once the batch has overflowed the accumulator pins at full scale.
   assign w_accNext = w_ovfNext ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_accNext = w_sum[ACC_W-1:0];
`endif

   // Two-state controller: ACC collects COUNT products, HOLD presents the
   // result until the consumer takes it. The last accept loads the result
   // and restarts the accumulator in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ACC;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_outValid <= 1'b0;
         r_outSum   <= '0;
         r_outOvf   <= 1'b0;
      end else if (i_clear) begin
         r_state    <= ST_ACC;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (w_accept) begin
                  if (r_cnt == LAST_IDX) begin
                     r_outSum   <= w_accNext;
                     r_outOvf   <= w_ovfNext;
                     r_outValid <= 1'b1;
                     r_state    <= ST_HOLD;
                     r_acc      <= '0;
                     r_cnt      <= '0;
                     r_ovf      <= 1'b0;
                  end else begin
                     r_acc <= w_accNext;
                     r_cnt <= r_cnt + 4'd1;
                     r_ovf <= w_ovfNext;
                  end
               end
            end
            ST_HOLD: begin
               if (r_outValid && io_bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= ST_ACC;
               end
            end
            default: begin
               r_state <= ST_ACC;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = w_inReady;
   assign io_bus.out_valid = r_outValid;
   assign io_bus.out_sum   = r_outSum;
   assign io_bus.out_ovf   = r_outOvf;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Four accumulator instances with different COUNT/ACC_W share one clock and
// reset. A behavioural model per instance keeps the running batch total as
// a plain integer and derives the result from it (wrap = total mod 2^W,
// saturate = min(total, 2^W-1), overflow = total > 2^W-1). One compare
// process checks every instance on every falling edge; directed sequences
// pin the model with hand-computed results, then randomized traffic runs.
// Define ACC_SATURATE_EN for both RTL and bench to exercise saturation.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   localparam int NDUT = 4;
   localparam int CNT [NDUT] = '{4, 2, 1, 3};
   localparam int WID [NDUT] = '{12, 8, 8, 8};

   logic clk;
   logic rst_n;

   logic       vIn  [NDUT];
   logic [7:0] pIn  [NDUT];
   logic       oRdy [NDUT];
   logic       clr  [NDUT];

   logic        rdyW [NDUT];
   logic        valW [NDUT];
   logic        ovfW [NDUT];
   logic [15:0] sumW [NDUT];

   int errors = 0;
   int checks = 0;

   // Model state per instance.
   bit mHold   [NDUT];
   int mSum    [NDUT];
   int mCnt    [NDUT];
   int mOutSum [NDUT];
   bit mOutOvf [NDUT];

   product_accumulator_if #(.ACC_W(12)) bus0 ();
   product_accumulator_if #(.ACC_W(8))  bus1 ();
   product_accumulator_if #(.ACC_W(8))  bus2 ();
   product_accumulator_if #(.ACC_W(8))  bus3 ();

   product_accumulator #(.COUNT(4), .ACC_W(12)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_clear(clr[0]), .io_bus(bus0));
   product_accumulator #(.COUNT(2), .ACC_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_clear(clr[1]), .io_bus(bus1));
   product_accumulator #(.COUNT(1), .ACC_W(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_clear(clr[2]), .io_bus(bus2));
   product_accumulator #(.COUNT(3), .ACC_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_clear(clr[3]), .io_bus(bus3));

   assign bus0.in_valid = vIn[0]; assign bus0.in_prod = pIn[0]; assign bus0.out_ready = oRdy[0];
   assign bus1.in_valid = vIn[1]; assign bus1.in_prod = pIn[1]; assign bus1.out_ready = oRdy[1];
   assign bus2.in_valid = vIn[2]; assign bus2.in_prod = pIn[2]; assign bus2.out_ready = oRdy[2];
   assign bus3.in_valid = vIn[3]; assign bus3.in_prod = pIn[3]; assign bus3.out_ready = oRdy[3];

   assign rdyW[0] = bus0.in_ready; assign valW[0] = bus0.out_valid;
   assign rdyW[1] = bus1.in_ready; assign valW[1] = bus1.out_valid;
   assign rdyW[2] = bus2.in_ready; assign valW[2] = bus2.out_valid;
   assign rdyW[3] = bus3.in_ready; assign valW[3] = bus3.out_valid;
   assign ovfW[0] = bus0.out_ovf;  assign sumW[0] = 16'(bus0.out_sum);
   assign ovfW[1] = bus1.out_ovf;  assign sumW[1] = 16'(bus1.out_sum);
   assign ovfW[2] = bus2.out_ovf;  assign sumW[2] = 16'(bus2.out_sum);
   assign ovfW[3] = bus3.out_ovf;  assign sumW[3] = 16'(bus3.out_sum);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int maxVal(input int w);
      return (1 << w) - 1;
   endfunction

   // Batch result from the exact integer total of its products.
   function automatic int foldSum(input int total, input int w);
`ifdef ACC_SATURATE_EN
      return (total > maxVal(w)) ? maxVal(w) : total;
`else
      return total & maxVal(w);
`endif
   endfunction

   task automatic checkOutput(input string name, input int k,
                              input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s dut%0d at %0t: got %0d, expected %0d",
                  name, k, $time, actual, expected);
      end
   endtask

   // Model update: one process per instance, evaluated on the same edge the
   // DUT samples its inputs.
   for (genvar g = 0; g < NDUT; g++) begin : gModel
      initial begin
         mHold[g] = 1'b0; mSum[g] = 0; mCnt[g] = 0; mOutSum[g] = 0; mOutOvf[g] = 1'b0;
      end
      always @(posedge clk) begin
         if (!rst_n) begin
            mHold[g]   <= 1'b0;
            mSum[g]    <= 0;
            mCnt[g]    <= 0;
            mOutSum[g] <= 0;
            mOutOvf[g] <= 1'b0;
         end else if (clr[g]) begin
            mHold[g] <= 1'b0;
            mSum[g]  <= 0;
            mCnt[g]  <= 0;
         end else if (mHold[g]) begin
            if (oRdy[g]) mHold[g] <= 1'b0;
         end else if (vIn[g]) begin
            if (mCnt[g] + 1 == CNT[g]) begin
               mHold[g]   <= 1'b1;
               mOutSum[g] <= foldSum(mSum[g] + int'(pIn[g]), WID[g]);
               mOutOvf[g] <= (mSum[g] + int'(pIn[g])) > maxVal(WID[g]);
               mSum[g]    <= 0;
               mCnt[g]    <= 0;
            end else begin
               mSum[g] <= mSum[g] + int'(pIn[g]);
               mCnt[g] <= mCnt[g] + 1;
            end
         end
      end
   end

   // Compare every instance against the model on each falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (!rst_n) begin
            checkOutput("in_ready",  k, int'(rdyW[k]), int'(!clr[k]));
            checkOutput("out_valid", k, int'(valW[k]), 0);
            checkOutput("out_sum",   k, int'(sumW[k]), 0);
            checkOutput("out_ovf",   k, int'(ovfW[k]), 0);
         end else begin
            checkOutput("in_ready",  k, int'(rdyW[k]), int'(!mHold[k] && !clr[k]));
            checkOutput("out_valid", k, int'(valW[k]), int'(mHold[k]));
            checkOutput("out_sum",   k, int'(sumW[k]), mOutSum[k]);
            checkOutput("out_ovf",   k, int'(ovfW[k]), int'(mOutOvf[k]));
         end
      end
   end

   // Drive one instance for one cycle; returns 1 time unit after the edge.
   task automatic applyStimulus(input int k, input logic v, input logic [7:0] p,
                                input logic r, input logic c);
      vIn[k]  = v;
      pIn[k]  = p;
      oRdy[k] = r;
      clr[k]  = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         vIn[k] = 1'b0; pIn[k] = 8'd0; oRdy[k] = 1'b1; clr[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pin_rst_valid", 0, int'(valW[0]), 0);
      checkOutput("pin_rst_sum",   0, int'(sumW[0]), 0);
      checkOutput("pin_rst_ready", 0, int'(rdyW[0]), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic batch: 225+12+0+63 = 300.
      applyStimulus(0, 1'b1, 8'd225, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd12,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd0,   1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd63,  1'b1, 1'b0);
      checkOutput("pin_basic_valid", 0, int'(valW[0]), 1);
      checkOutput("pin_basic_sum",   0, int'(sumW[0]), 300);
      checkOutput("pin_basic_ovf",   0, int'(ovfW[0]), 0);
      checkOutput("pin_basic_ready", 0, int'(rdyW[0]), 0);
      applyStimulus(0, 1'b0, 8'd0, 1'b1, 1'b0);
      checkOutput("pin_basic_done", 0, int'(valW[0]), 0);
      checkOutput("pin_basic_rdy2", 0, int'(rdyW[0]), 1);

      // Backpressure: batch 1+2+3+4 = 10 held for five cycles.
      applyStimulus(0, 1'b1, 8'd1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd2, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd3, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd4, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1'b1, 8'd99, 1'b0, 1'b0);
         checkOutput("pin_bp_ready", 0, int'(rdyW[0]), 0);
         checkOutput("pin_bp_sum",   0, int'(sumW[0]), 10);
      end
      applyStimulus(0, 1'b1, 8'd99, 1'b1, 1'b0);
      checkOutput("pin_bp_release", 0, int'(valW[0]), 0);
      checkOutput("pin_bp_rdy",     0, int'(rdyW[0]), 1);
      applyStimulus(0, 1'b1, 8'd99, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd1,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd1,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd1,  1'b1, 1'b0);
      checkOutput("pin_bp_next", 0, int'(sumW[0]), 102);
      applyStimulus(0, 1'b0, 8'd0, 1'b1, 1'b0);

      // Overflow: 200+100 = 300 in 8 bits; 200+100+10 = 310 across 3.
      applyStimulus(1, 1'b1, 8'd200, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 8'd100, 1'b1, 1'b0);
`ifdef ACC_SATURATE_EN
      checkOutput("pin_ovf_sum", 1, int'(sumW[1]), 255);
`else
      checkOutput("pin_ovf_sum", 1, int'(sumW[1]), 44);
`endif
      checkOutput("pin_ovf_flag", 1, int'(ovfW[1]), 1);
      applyStimulus(1, 1'b0, 8'd0, 1'b1, 1'b0);
      applyStimulus(3, 1'b1, 8'd200, 1'b1, 1'b0);
      applyStimulus(3, 1'b1, 8'd100, 1'b1, 1'b0);
      applyStimulus(3, 1'b1, 8'd10,  1'b1, 1'b0);
`ifdef ACC_SATURATE_EN
      checkOutput("pin_sticky_sum", 3, int'(sumW[3]), 255);
`else
      checkOutput("pin_sticky_sum", 3, int'(sumW[3]), 54);
`endif
      checkOutput("pin_sticky_ovf", 3, int'(ovfW[3]), 1);
      applyStimulus(3, 1'b0, 8'd0, 1'b1, 1'b0);

      // Clear mid-batch discards 50+60; then 1+2+3+4 = 10.
      applyStimulus(0, 1'b1, 8'd50, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd60, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd77, 1'b1, 1'b1);
      applyStimulus(0, 1'b1, 8'd1,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd2,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd3,  1'b1, 1'b0);
      applyStimulus(0, 1'b1, 8'd4,  1'b1, 1'b0);
      checkOutput("pin_clear_sum", 0, int'(sumW[0]), 10);
      checkOutput("pin_clear_ovf", 0, int'(ovfW[0]), 0);
      applyStimulus(0, 1'b0, 8'd0, 1'b1, 1'b0);

      // COUNT=1: 7 then 9, two cycles apart.
      applyStimulus(2, 1'b1, 8'd7, 1'b1, 1'b0);
      checkOutput("pin_c1_first", 2, int'(sumW[2]), 7);
      applyStimulus(2, 1'b1, 8'd9, 1'b1, 1'b0);
      checkOutput("pin_c1_gap", 2, int'(valW[2]), 0);
      applyStimulus(2, 1'b1, 8'd9, 1'b1, 1'b0);
      checkOutput("pin_c1_second", 2, int'(sumW[2]), 9);
      applyStimulus(2, 1'b0, 8'd0, 1'b1, 1'b0);

      // Async reset while holding a result.
      applyStimulus(0, 1'b1, 8'd10, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd20, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd30, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 8'd40, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 8'd40, 1'b0, 1'b0);
      checkOutput("pin_hold_sum", 0, int'(sumW[0]), 100);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("pin_arst_valid", 0, int'(valW[0]), 0);
      checkOutput("pin_arst_sum",   0, int'(sumW[0]), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 8'd225, 1'b1, 1'b0);
      checkOutput("pin_arst_900", 0, int'(sumW[0]), 900);
      applyStimulus(0, 1'b0, 8'd0, 1'b1, 1'b0);

      // Randomized traffic on all instances at once.
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < NDUT; k++) begin
            vIn[k]  = ($urandom_range(0, 9) < 7);
            pIn[k]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                                 : 8'($urandom_range(0, 255));
            oRdy[k] = ($urandom_range(0, 9) < 6);
            clr[k]  = ($urandom_range(0, 39) == 0);
         end
         @(posedge clk);
         #1;
      end

      for (int k = 0; k < NDUT; k++) begin
         vIn[k] = 1'b0; oRdy[k] = 1'b1; clr[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
